// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and decodes make codes.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       data_ready,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Frame FSM states; state_q is the observable frame state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    logic          clk_meta_q, clk_sync_q;
    logic          data_meta_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_edge;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    key_q, key_d;
    logic          dr_q, dr_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;

    // Synchronizers and filter preset high so reset looks like an idle bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Edge is flagged in the same cycle the sampled data is still current.
    assign fall_edge = filt_q & ~filt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            key_q     <= '0;
            dr_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            key_q     <= key_d;
            dr_q      <= dr_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
        end
    end

    always_comb begin
        if (state_q == IDLE || fall_edge) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign timeout = (state_q != IDLE) && !fall_edge &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        key_d     = key_q;
        dr_d      = 1'b0;
        pe_d      = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_edge && !data_sync_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    shift_d = {data_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall_edge) begin
                    par_d   = data_sync_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    // A bad stop bit outranks a bad parity bit.
                    if (!data_sync_q) begin
                        fe_d  = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else if (^{shift_q, par_q} == 1'b0) begin
                        pe_d  = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        case (shift_q)
                            8'hF0: brk_d = 1'b1;
                            8'hE0: ext_d = 1'b1;
                            default: begin
                                if (!brk_q) begin
                                    key_d = shift_q;
                                    dr_d  = 1'b1;
                                end
                                brk_d = 1'b0;
                                ext_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            fe_d      = 1'b1;
            brk_d     = 1'b0;
            ext_d     = 1'b0;
        end
    end

    assign key_code   = key_q;
    assign data_ready = dr_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 The block SHALL expose the following parameters:
- FILTER_LEN, 4, consecutive equal samples required to accept a new ps2_clk level.
- TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between filtered ps2_clk falling edges inside a frame.

REQ-002 The block SHALL expose the following ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  PS/2 device clock; asynchronous to clk.
- ps2_data  in  1  PS/2 device data; asynchronous to clk.
- key_code  out  8  last accepted make code; held until the next accepted make code.
- data_ready  out  1  one-cycle pulse when key_code is updated.
- parity_err  out  1  one-cycle pulse when a frame is dropped for bad parity.
- frame_err  out  1  one-cycle pulse when a frame is dropped for a bad stop bit or a timeout.

Function
REQ-003 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer before any use.
REQ-004 The filtered ps2_clk SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; shorter pulses SHALL be ignored.
REQ-005 A falling edge SHALL be a filtered ps2_clk transition from 1 to 0; synchronized ps2_data SHALL be sampled only in the cycle of that edge.
REQ-006 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-007 In IDLE, a falling edge with data=0 SHALL go to DATA with bit count 0; a falling edge with data=1 SHALL be ignored.
REQ-008 In DATA, each falling edge SHALL shift data in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-009 In PARITY, the sampled bit SHALL be stored and the FSM SHALL go to STOP.
REQ-010 In STOP, the FSM SHALL return to IDLE and evaluate the frame: stop=0 gives a frame_err pulse; otherwise odd parity failure (data bits plus parity bit have an even count of ones) gives a parity_err pulse; otherwise the byte goes to the decoder.
REQ-011 If parity and stop are both bad, only frame_err SHALL pulse.
REQ-012 The timeout counter SHALL reset on every falling edge and SHALL run only outside IDLE; reaching TIMEOUT_CYCLES SHALL force IDLE, pulse frame_err and discard partial bits.
REQ-013 The decoder SHALL handle bytes as follows:
- 0xF0 sets the break flag.
- 0xE0 sets the extended flag.
- Any other byte with break=0 loads key_code and pulses data_ready.
- Any other byte with break=1 produces no pulse and clears the break flag.
- Break and extended flags clear after any non-prefix byte.
REQ-014 data_ready, key_code update and error pulses SHALL all occur in the cycle after the STOP-state falling edge (fixed latency of 1 clk from edge detection).
REQ-015 Any parity_err or frame_err event SHALL also clear the break and extended flags.
REQ-016 Repeated make codes (typematic) SHALL each produce a data_ready pulse; there is no duplicate suppression.
REQ-017 data_ready, parity_err and frame_err SHALL be mutually exclusive and never high for more than 1 consecutive cycle.

Reset
REQ-018 While rst_n=0 the block SHALL hold:
- key_code=0x00; data_ready, parity_err and frame_err=0.
- FSM in IDLE; bit count, shift register, timeout counter and flags cleared.
- Synchronizer and filter state preset to 1 (idle bus).
REQ-019 Asserting reset mid-frame SHALL discard the partial frame with no error pulse; the first complete frame after release SHALL decode normally.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Frame 0x6B, parity 0, stop 1 -> one data_ready pulse, key_code=0x6B, no error pulses.
- Frames E0 74, then E0 F0 74 -> one pulse with key_code=0x74; the break sequence produces no pulse and key_code stays 0x74.
- Frame 0x75 sent with parity 1 -> parity_err pulse, no data_ready, key_code unchanged; a following 0x75 with parity 0 -> pulse with key_code=0x75.
- Frame with stop=0 -> frame_err only; 4 bits then ps2_clk idle for TIMEOUT_CYCLES+10 -> frame_err, FSM in IDLE; next frame 0x72 with parity 1 -> key_code=0x72.
- Glitch of FILTER_LEN-1 cycles on ps2_clk during IDLE and during DATA -> no state change and no bit shifted.
- rst_n low after 5 data bits of a frame -> all outputs 0 with no pulse; after release, frame 0x6B -> key_code=0x6B, data_ready pulses once.
